alu_multicycle: RTL

Parametrised, multi-cycle integer ALU for the RV32I core, replacing the purely combinational ALU. Shifts are iterative, moving at most SHIFT_STEP bit positions per clock. All other RV32I ALU operations complete in one cycle. The control state machine drives it with a start/busy/done handshake, and its registered result feeds register-bank write-back.

---
 rtl/alu_multicycle.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle
// Multi-cycle integer ALU for the RV32I core. Single-cycle ops (ADD/SUB, SLT,
// SLTU, XOR, OR, AND) and zero-distance shifts finish at the capture edge.
// Shifts by a non-zero amount iterate, moving at most SHIFT_STEP bits per
// clock. The result is registered and accompanied by a one-cycle done pulse.
//
// Ports:
//   CLK      in   1     clock, rising edge
//   RESET    in   1     asynchronous active-high reset
//   start    in   1     operation request, sampled only when not busy
//   funct3   in   3     RV32I ALU operation select
//   funct7_5 in   1     instruction bit 30 (SUB / SRA select)
//   isReg    in   1     1 = OP (register form), 0 = OP-IMM
//   value1   in   XLEN  operand A
//   value2   in   XLEN  operand B (low SHAMT_W bits are the shift amount)
//   busy     out  1     high while an iterative shift is running
//   done     out  1     one-cycle pulse when result has just been updated
//   result   out  XLEN  registered result, held between completions

module alu_multicycle #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    parameter int SHAMT_W    = $clog2(XLEN)
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            isReg,
    input  logic [XLEN-1:0] value1,
    input  logic [XLEN-1:0] value2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // One extra bit so SHIFT_STEP itself is representable even when it
    // equals XLEN's maximum shift distance plus one (e.g. XLEN=8, step 8).
    localparam logic [SHAMT_W:0] STEP_MAX = SHIFT_STEP[SHAMT_W:0];

    state_t            r_state;
    state_t            w_nextState;
    logic [XLEN-1:0]   r_acc;
    logic [SHAMT_W-1:0] r_cnt;
    logic              r_left;
    logic              r_arith;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    logic [SHAMT_W-1:0] w_shamt;
    logic              w_isShift;
    logic              w_shiftNow;
    logic              w_accept;
    logic [XLEN-1:0]   w_opResult;
    logic [SHAMT_W:0]  w_step;
    logic [SHAMT_W-1:0] w_cntNext;
    logic [XLEN-1:0]   w_shifted;
    logic              w_lastStep;

    assign w_shamt    = value2[SHAMT_W-1:0];
    assign w_isShift  = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign w_shiftNow = w_isShift && (w_shamt != '0);
    assign w_accept   = start && (r_state == IDLE);

    // Single-cycle operation decode. Shift opcodes yield value1 here, which
    // is exactly the answer for a zero-distance shift; non-zero shifts go
    // through the iterative path instead.
    always_comb begin
        w_opResult = '0;
        case (funct3)
            3'b000:  w_opResult = (isReg && funct7_5) ? (value1 - value2) : (value1 + value2);
            3'b010:  w_opResult = {{(XLEN-1){1'b0}}, ($signed(value1) < $signed(value2))};
            3'b011:  w_opResult = {{(XLEN-1){1'b0}}, (value1 < value2)};
            3'b100:  w_opResult = value1 ^ value2;
            3'b110:  w_opResult = value1 | value2;
            3'b111:  w_opResult = value1 & value2;
            default: w_opResult = value1;
        endcase
    end

    // Per-cycle shift distance is min(remaining, SHIFT_STEP). An arithmetic
    // right shift of the accumulator keeps replicating its MSB, which is
    // still the original operand's sign bit.
    always_comb begin
        w_step = ({1'b0, r_cnt} < STEP_MAX) ? {1'b0, r_cnt} : STEP_MAX;
        w_cntNext = r_cnt - w_step[SHAMT_W-1:0];
        w_lastStep = (w_cntNext == '0);
        if (r_left) begin
            w_shifted = r_acc << w_step;
        end else if (r_arith) begin
            w_shifted = $unsigned($signed(r_acc) >>> w_step);
        end else begin
            w_shifted = r_acc >> w_step;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: only a non-zero shift ever leaves IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_shiftNow) w_nextState = SHIFT;
            SHIFT:   if (w_lastStep) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath: operand capture, iterative shifting, result and done pulse.
    // Operands are copied into the accumulator at capture so later changes
    // on value1/value2 cannot disturb a shift in flight.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_left   <= 1'b0;
            r_arith  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    if (w_shiftNow) begin
                        r_acc   <= value1;
                        r_cnt   <= w_shamt;
                        r_left  <= (funct3 == 3'b001);
                        r_arith <= (funct3 == 3'b101) && funct7_5;
                    end else begin
                        r_result <= w_opResult;
                        r_done   <= 1'b1;
                    end
                end
            end else begin
                r_acc <= w_shifted;
                r_cnt <= w_cntNext;
                if (w_lastStep) begin
                    r_result <= w_shifted;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign busy   = (r_state == SHIFT);
    assign done   = r_done;
    assign result = r_result;

endmodule
